// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared types and constants for the LCD raster controller:
//   lcd_mode_e  - pixel source selector (black, test pattern, stream, solid)
//   lcd_state_e - mode-change FSM state (RUN / PEND)
//   BAR_*       - colour-bar constants at 8 bits per channel; the pattern
//                 generator widens each channel to CW bits.
//   bar_color() - bar index (0..7) to 24-bit colour.
// ---------------------------------------------------------------------------
package lcd_pkg;

   typedef enum logic [1:0] {
      LCD_BLACK   = 2'd0,
      LCD_TESTPAT = 2'd1,
      LCD_STREAM  = 2'd2,
      LCD_SOLID   = 2'd3
   } lcd_mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } lcd_state_e;

   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_color = BAR_WHITE;
         3'd1:    bar_color = BAR_YELLOW;
         3'd2:    bar_color = BAR_CYAN;
         3'd3:    bar_color = BAR_GREEN;
         3'd4:    bar_color = BAR_MAGENTA;
         3'd5:    bar_color = BAR_RED;
         3'd6:    bar_color = BAR_BLUE;
         default: bar_color = BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/lcd_raster_ctrl_testpat.sv
// ---------------------------------------------------------------------------
// lcd_testpat
// Eight-bar vertical colour pattern, H_ACTIVE/8 pixels per bar, with no
// divider: a pixel-in-bar counter and a bar index advance on every active
// pixel and restart at the first active column of each line.
// Ports:
//   iCLK, iRST_n  - pixel clock, asynchronous active-low reset
//   active        - current (x,y) lies in the active area
//   line_start    - x == H_BLANK (first active column)
//   rgb           - {R,G,B} for the current pixel, combinational
// ---------------------------------------------------------------------------
module lcd_testpat
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = 800,
   parameter int CW       = 8
) (
   input  logic            iCLK,
   input  logic            iRST_n,
   input  logic            active,
   input  logic            line_start,
   output logic [3*CW-1:0] rgb
);

   localparam int BAR_W = H_ACTIVE / 8;
   localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   logic [BW-1:0] pix_cnt;
   logic [BW-1:0] cur_cnt;
   logic [2:0]    bar;
   logic [2:0]    cur_bar;
   logic [23:0]   bar_rgb;

   // At the first active column the pattern must already show bar 0, so the
   // restart is applied combinationally rather than a cycle late.
   always_comb begin
      cur_cnt = line_start ? '0   : pix_cnt;
      cur_bar = line_start ? 3'd0 : bar;
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         pix_cnt <= '0;
         bar     <= 3'd0;
      end else if (line_start || active) begin
         if (cur_cnt == BAR_LAST) begin
            pix_cnt <= '0;
            bar     <= cur_bar + 3'd1;
         end else begin
            pix_cnt <= cur_cnt + 1'b1;
            bar     <= cur_bar;
         end
      end
   end

   // Bar colours are full-on/full-off per channel, so the channel MSB is
   // enough to widen 8-bit constants to CW bits.
   assign bar_rgb = bar_color(cur_bar);
   assign rgb     = {{CW{bar_rgb[23]}}, {CW{bar_rgb[15]}}, {CW{bar_rgb[7]}}};

endmodule

// File: rtl/lcd_raster_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_raster_ctrl
// Parametrised LCD raster controller. Generates HD/VD/DE from porch/sync
// parameters, picks the pixel source per frame (black, colour bars, solid
// colour, or a ready/valid pixel stream) and tracks stream underflows.
// Optional feature macro: LCD_TESTPAT_EN (colour bars on mode 1; without it
// mode 1 displays black).
// Ports:
//   iCLK, iRST_n          - pixel clock, asynchronous active-low reset
//   iMode                 - requested source (0 black,1 bars,2 stream,3 solid)
//   iColor                - solid colour {R,G,B}
//   iPIX_DATA/iPIX_VALID  - stream pixel and its valid
//   oPIX_READY            - stream pixel consumed this cycle if valid
//   oHD, oVD, oDE         - syncs (active low) and data enable, registered
//   oLCD_R/G/B            - colour data, registered
//   oX, oY                - raw raster counters
//   oNewFrame, oEndFrame  - (0,0) pulse / last-active-pixel pulse
//   oActiveMode           - source currently displayed
//   oModePending          - mode FSM is in PEND (debug view of FSM state)
//   oUnderflow            - sticky underflow flag for the current frame
//   oUnderflowCnt         - saturating underflow count, cleared by reset only
// Stream handshake: oPIX_READY depends only on the counters and the active
// mode, never on iPIX_VALID; a pixel is transferred on every rising edge
// where oPIX_READY && iPIX_VALID, and ready && !valid is an underflow that
// displays black for that pixel.
// ---------------------------------------------------------------------------
module lcd_raster_ctrl
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = 800,
   parameter int H_BLANK  = 46,
   parameter int H_FP     = 210,
   parameter int H_SYNC   = 1,
   parameter int V_ACTIVE = 480,
   parameter int V_BLANK  = 23,
   parameter int V_FP     = 22,
   parameter int V_SYNC   = 1,
   parameter int CW       = 8
) (
   input  logic                                           iCLK,
   input  logic                                           iRST_n,
   input  logic [1:0]                                     iMode,
   input  logic [3*CW-1:0]                                iColor,
   input  logic [3*CW-1:0]                                iPIX_DATA,
   input  logic                                           iPIX_VALID,
   output logic                                           oPIX_READY,
   output logic                                           oHD,
   output logic                                           oVD,
   output logic                                           oDE,
   output logic [CW-1:0]                                  oLCD_R,
   output logic [CW-1:0]                                  oLCD_G,
   output logic [CW-1:0]                                  oLCD_B,
   output logic [$clog2(H_BLANK+H_ACTIVE+H_FP)-1:0]       oX,
   output logic [$clog2(V_BLANK+V_ACTIVE+V_FP)-1:0]       oY,
   output logic                                           oNewFrame,
   output logic                                           oEndFrame,
   output logic [1:0]                                     oActiveMode,
   output logic                                           oModePending,
   output logic                                           oUnderflow,
   output logic [15:0]                                    oUnderflowCnt
);

   localparam int H_LINE = H_BLANK + H_ACTIVE + H_FP;
   localparam int V_LINE = V_BLANK + V_ACTIVE + V_FP;
   localparam int XW     = $clog2(H_LINE);
   localparam int YW     = $clog2(V_LINE);

   localparam logic [XW-1:0] X_LAST      = XW'(H_LINE - 1);
   localparam logic [XW-1:0] X_ACT_FIRST = XW'(H_BLANK);
   localparam logic [XW-1:0] X_ACT_LAST  = XW'(H_BLANK + H_ACTIVE - 1);
   localparam logic [XW-1:0] X_SYNC_END  = XW'(H_SYNC);
   localparam logic [YW-1:0] Y_LAST      = YW'(V_LINE - 1);
   localparam logic [YW-1:0] Y_ACT_FIRST = YW'(V_BLANK);
   localparam logic [YW-1:0] Y_ACT_LAST  = YW'(V_BLANK + V_ACTIVE - 1);
   localparam logic [YW-1:0] Y_SYNC_END  = YW'(V_SYNC);

   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic            x_last, y_last, frame_last, active;
   logic            ready, underflow;
   lcd_state_e      state;
   lcd_mode_e       active_mode, req_mode;
   logic [3*CW-1:0] tp_rgb;
   logic [3*CW-1:0] pix_next, pix;
   logic            hd, vd, de;

   // ---------------- raster counters ----------------
   assign x_last     = (x == X_LAST);
   assign y_last     = (y == Y_LAST);
   assign frame_last = x_last && y_last;
   assign active     = (x >= X_ACT_FIRST) && (x <= X_ACT_LAST) &&
                       (y >= Y_ACT_FIRST) && (y <= Y_ACT_LAST);

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         x <= '0;
         y <= '0;
      end else if (x_last) begin
         x <= '0;
         y <= y_last ? '0 : y + 1'b1;
      end else begin
         x <= x + 1'b1;
      end
   end

   // ---------------- mode FSM ----------------
   // A new source is only adopted on the last edge of a frame, so a frame
   // that has started is always finished in the mode it began with.
   assign req_mode = lcd_mode_e'(iMode);

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state       <= ST_RUN;
         active_mode <= LCD_BLACK;
      end else begin
         case (state)
            ST_RUN: begin
               if (req_mode != active_mode) state <= ST_PEND;
            end
            ST_PEND: begin
               if (req_mode == active_mode) begin
                  state <= ST_RUN;
               end else if (frame_last) begin
                  state       <= ST_RUN;
                  active_mode <= req_mode;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   // ---------------- test pattern ----------------
`ifdef LCD_TESTPAT_EN
   logic line_start;
   assign line_start = (x == X_ACT_FIRST);

   lcd_testpat #(
      .H_ACTIVE (H_ACTIVE),
      .CW       (CW)
   ) u_testpat (
      .iCLK       (iCLK),
      .iRST_n     (iRST_n),
      .active     (active),
      .line_start (line_start),
      .rgb        (tp_rgb)
   );
`else
   assign tp_rgb = '0;
`endif

   // ---------------- stream handshake ----------------
   assign ready     = active && (active_mode == LCD_STREAM);
   assign underflow = ready && !iPIX_VALID;

   // ---------------- pixel source select ----------------
   always_comb begin
      pix_next = '0;
      if (active) begin
         case (active_mode)
            LCD_TESTPAT: pix_next = tp_rgb;
            LCD_STREAM:  pix_next = iPIX_VALID ? iPIX_DATA : '0;
            LCD_SOLID:   pix_next = iColor;
            default:     pix_next = '0;
         endcase
      end
   end

   // ---------------- output registers ----------------
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         hd  <= 1'b0;
         vd  <= 1'b0;
         de  <= 1'b0;
         pix <= '0;
      end else begin
         hd  <= (x >= X_SYNC_END);
         vd  <= (y >= Y_SYNC_END);
         de  <= active;
         pix <= pix_next;
      end
   end

   // ---------------- underflow tracking ----------------
   // The (0,0) cycle is always blanking, so clearing there cannot race with
   // a new underflow.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         oUnderflow    <= 1'b0;
         oUnderflowCnt <= 16'd0;
      end else begin
         if (oNewFrame)      oUnderflow <= 1'b0;
         else if (underflow) oUnderflow <= 1'b1;
         if (underflow && (oUnderflowCnt != 16'hFFFF))
            oUnderflowCnt <= oUnderflowCnt + 16'd1;
      end
   end

   assign oPIX_READY   = ready;
   assign oHD          = hd;
   assign oVD          = vd;
   assign oDE          = de;
   assign oLCD_R       = pix[3*CW-1:2*CW];
   assign oLCD_G       = pix[2*CW-1:CW];
   assign oLCD_B       = pix[CW-1:0];
   assign oX           = x;
   assign oY           = y;
   assign oNewFrame    = (x == '0) && (y == '0);
   assign oEndFrame    = (x == X_ACT_LAST) && (y == Y_ACT_LAST);
   assign oActiveMode  = active_mode;
   assign oModePending = (state == ST_PEND);

endmodule
